// File: rtl/vec_stream_pkg.sv
// Shared types for the vector stream transmitter.
// Element width, vector length and derived index width.
package vec_stream_pkg;

  parameter int T = 16;
  parameter int N = 4;

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef logic signed [T-1:0] elem_t;
  typedef elem_t [N-1:0] vec_t;

endpackage

// File: rtl/vec_stream_tx_if.sv
// Parallel vector input and serial element output bundle.
// master = transmitter side, slave = producer/consumer side.
interface vec_stream_tx_if;
  import vec_stream_pkg::*;

  logic  vec_valid;
  logic  vec_ready;
  vec_t  vec_in;
  logic  m_valid;
  logic  m_ready;
  elem_t data_out;
  logic  m_last;

  modport master (
    input  vec_valid,
    input  vec_in,
    input  m_ready,
    output vec_ready,
    output m_valid,
    output data_out,
    output m_last
  );

  modport slave (
    output vec_valid,
    output vec_in,
    output m_ready,
    input  vec_ready,
    input  m_valid,
    input  data_out,
    input  m_last
  );

endinterface

// File: rtl/vec_fifo2.sv
// Two-entry register FIFO of whole vectors.
// Head reads as zero while empty so stale data never leaks out.
module vec_fifo2
  import vec_stream_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  vec_t din,
  output vec_t head,
  output logic full,
  output logic empty
);

  vec_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        cnt <= cnt + 2'd1;
      end else if (pop && !push) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vec_stream_tx.sv
// Parallel-to-serial vector transmitter.
// Buffers two vectors and emits their elements one per handshake.
module vec_stream_tx
  import vec_stream_pkg::*;
(
  input  logic clk,
  input  logic reset,
  vec_stream_tx_if.master bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] idx;
  vec_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             fire;
  logic             at_last;

  // vec_ready depends on registered occupancy only
  assign push    = bus.vec_valid && !full;
  assign fire    = !empty && bus.m_ready;
  assign at_last = (idx == LAST);
  assign pop     = fire && at_last;

  vec_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.vec_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (fire) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

  assign bus.vec_ready = !full;
  assign bus.m_valid   = !empty;
  assign bus.data_out  = head[idx];
  assign bus.m_last    = !empty && at_last;

endmodule

// File: tb/tb_vec_stream_tx.sv
// Self-checking bench for vec_stream_tx.
// Fixed vector tables, corner sequences and a randomized queue model.
module tb_vec_stream_tx;
  import vec_stream_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vec_stream_tx_if bus ();

  vec_stream_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic  vv;
    vec_t  vi;
    logic  mr;
    logic  ev;
    elem_t ed;
    logic  el;
    logic  er;
  } row_t;

  row_t tab[$];

  // reference model: queue of pending vectors plus position in head vector
  vec_t mq[$];
  int   pos = 0;
  int   sent = 0;

  logic  prev_stall = 1'b0;
  elem_t prev_d     = '0;
  logic  prev_l     = 1'b0;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endfunction

  function automatic vec_t mkv(int a, int b, int c, int d);
    vec_t v;
    v[0] = elem_t'(a);
    v[1] = elem_t'(b);
    v[2] = elem_t'(c);
    v[3] = elem_t'(d);
    return v;
  endfunction

  function automatic row_t mkr(logic vv, vec_t vi, logic mr, logic ev,
                               int ed, logic el, logic er);
    row_t r;
    r.vv = vv; r.vi = vi; r.mr = mr;
    r.ev = ev; r.ed = elem_t'(ed); r.el = el; r.er = er;
    return r;
  endfunction

  function automatic vec_t rndv();
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = elem_t'($urandom);
    return v;
  endfunction

  task automatic check_idle(string nm);
    chk({nm, "_valid"}, 32'(bus.m_valid), 32'd0);
    chk({nm, "_last"}, 32'(bus.m_last), 32'd0);
    chk({nm, "_ready"}, 32'(bus.vec_ready), 32'd1);
    chk({nm, "_data"}, 32'(bus.data_out), 32'd0);
  endtask

  task automatic do_reset(string nm);
    #2 reset = 1'b1;
    #1 check_idle(nm);
    bus.vec_valid = 1'b0;
    bus.m_ready   = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    mq.delete();
    pos = 0;
    prev_stall = 1'b0;
  endtask

  task automatic run_table(string nm);
    for (int i = 0; i < tab.size(); i++) begin
      bus.vec_valid = tab[i].vv;
      bus.vec_in    = tab[i].vi;
      bus.m_ready   = tab[i].mr;
      chk($sformatf("%s[%0d].valid", nm, i), 32'(bus.m_valid),
          32'(tab[i].ev));
      chk($sformatf("%s[%0d].data", nm, i), 32'(bus.data_out),
          32'(tab[i].ed));
      chk($sformatf("%s[%0d].last", nm, i), 32'(bus.m_last),
          32'(tab[i].el));
      chk($sformatf("%s[%0d].ready", nm, i), 32'(bus.vec_ready),
          32'(tab[i].er));
      @(posedge clk);
      #1;
    end
    bus.vec_valid = 1'b0;
  endtask

  // one cycle: drive, compare against the model, advance edge, update model
  task automatic cycle(logic vv, vec_t vi, logic mr);
    logic  ev, el, er, acc, rel;
    elem_t ed;
    bus.vec_valid = vv;
    bus.vec_in    = vi;
    bus.m_ready   = mr;
    ev = (mq.size() != 0);
    ed = ev ? mq[0][pos] : elem_t'(0);
    el = ev && (pos == N - 1);
    er = (mq.size() < 2);
    chk("m_valid", 32'(bus.m_valid), 32'(ev));
    chk("data_out", 32'(bus.data_out), 32'(ed));
    chk("m_last", 32'(bus.m_last), 32'(el));
    chk("vec_ready", 32'(bus.vec_ready), 32'(er));
    if (prev_stall) begin
      chk("stall_data", 32'(bus.data_out), 32'(prev_d));
      chk("stall_last", 32'(bus.m_last), 32'(prev_l));
    end
    prev_stall = bus.m_valid && !mr;
    prev_d     = bus.data_out;
    prev_l     = bus.m_last;
    acc = vv && er;
    rel = ev && mr;
    @(posedge clk);
    #1;
    if (rel) begin
      pos++;
      if (pos == N) begin
        pos = 0;
        void'(mq.pop_front());
      end
    end
    if (acc) begin
      mq.push_back(vi);
      sent++;
    end
  endtask

  task automatic drain(int budget);
    int c = 0;
    while (mq.size() != 0 && c < budget) begin
      cycle(1'b0, rndv(), 1'b1);
      c++;
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  vec_t va, vb, vc, vx;
  int   cyc;

  initial begin
    bus.vec_valid = 1'b0;
    bus.vec_in    = '0;
    bus.m_ready   = 1'b0;
    va = mkv(1, 2, 3, 4);
    vb = mkv(5, 6, 7, 8);
    vc = mkv(9, 10, 11, 12);

    #7 check_idle("rst0");
    @(posedge clk);
    #1 reset = 1'b0;

    // single vector with signed values
    tab.delete();
    tab.push_back(mkr(1, mkv(10, -20, 30, -40), 1, 0, 0, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, 10, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, -20, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, 30, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, -40, 1, 1));
    tab.push_back(mkr(0, '0, 1, 0, 0, 0, 1));
    run_table("single");

    // fill, back-pressure, then zero-bubble drain
    do_reset("rst1");
    tab.delete();
    tab.push_back(mkr(1, va, 0, 0, 0, 0, 1));
    tab.push_back(mkr(1, vb, 0, 1, 1, 0, 1));
    tab.push_back(mkr(1, vc, 0, 1, 1, 0, 0));
    tab.push_back(mkr(1, vc, 1, 1, 1, 0, 0));
    tab.push_back(mkr(1, vc, 1, 1, 2, 0, 0));
    tab.push_back(mkr(1, vc, 1, 1, 3, 0, 0));
    tab.push_back(mkr(1, vc, 1, 1, 4, 1, 0));
    tab.push_back(mkr(1, vc, 1, 1, 5, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, 6, 0, 0));
    tab.push_back(mkr(0, '0, 1, 1, 7, 0, 0));
    tab.push_back(mkr(0, '0, 1, 1, 8, 1, 0));
    tab.push_back(mkr(0, '0, 1, 1, 9, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, 10, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, 11, 0, 1));
    tab.push_back(mkr(0, '0, 1, 1, 12, 1, 1));
    tab.push_back(mkr(0, '0, 1, 0, 0, 0, 1));
    run_table("backpress");

    // accept on the same edge the only vector's last element leaves
    do_reset("rst2");
    cycle(1'b1, va, 1'b1);
    cycle(1'b0, vx, 1'b1);
    cycle(1'b0, vx, 1'b1);
    cycle(1'b0, vx, 1'b1);
    cycle(1'b1, vc, 1'b1);
    chk("swap_ready", 32'(bus.vec_ready), 32'd1);
    chk("swap_data", 32'(bus.data_out), 32'd9);
    cycle(1'b1, vb, 1'b1);
    drain(20);

    // async reset mid-vector
    do_reset("rst3");
    cycle(1'b1, mkv(100, 200, 300, 400), 1'b1);
    cycle(1'b0, vx, 1'b1);
    cycle(1'b0, vx, 1'b1);
    chk("mid_data", 32'(bus.data_out), 32'd300);
    do_reset("rstmid");
    cycle(1'b1, mkv(7, 8, 9, 10), 1'b1);
    chk("post_rst_data", 32'(bus.data_out), 32'd7);
    drain(20);

    // hammer a full buffer
    do_reset("rst4");
    cycle(1'b1, va, 1'b0);
    cycle(1'b1, vb, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, mkv(-1, -1, -1, -1), 1'b0);
    chk("full_ready", 32'(bus.vec_ready), 32'd0);
    chk("full_head", 32'(bus.data_out), 32'd1);
    drain(20);

    // randomized traffic against the queue model
    do_reset("rst5");
    sent = 0;
    cyc  = 0;
    while ((sent < 200 || mq.size() != 0) && cyc < 5000) begin
      cycle(sent < 200 && $urandom_range(0, 3) != 0, rndv(),
            1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd200);
    chk("rand_empty", 32'(mq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
